// File: rtl/hsv_core_flush_pkg.sv
// Shared types and defaults for the core flush handshake controller.
package hsv_core_flush_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    HOLD  = 2'd2,
    FALL  = 2'd3
  } flush_state_e;

  localparam int DEF_TIMEOUT     = 1024;
  localparam int DEF_HOLD_CYCLES = 1;

endpackage

// File: rtl/hsv_core_flush_timeout.sv
// Saturating phase-wait counter; expired flags the last allowed waiting cycle.
module hsv_core_flush_timeout
  import hsv_core_flush_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk_core,
  input  logic rst_core,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TMR_W < 1) ? 1 : TMR_W;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk_core) begin
        if (rst_core || clr) begin
          cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign expired = (cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// N-channel four-phase flush req/ack sequencer with minimum hold, timeout
// with forced progress, and stuck-channel reporting.
module hsv_core_flush_ctrl
  import hsv_core_flush_pkg::*;
#(
  parameter int NUM_ACKS    = 9,
  parameter int TARGET_W    = 32,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TMR_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [TARGET_W-1:0] start_target,
  input  logic [NUM_ACKS-1:0] ack_enable,
  input  logic [NUM_ACKS-1:0] flush_ack,
  output logic                flush_req,
  output logic [TARGET_W-1:0] flush_target,
  output logic                flush_busy,
  output logic                flush_done,
  output logic                timeout_o,
  output logic [NUM_ACKS-1:0] stuck_o,
  input  logic                clear_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  flush_state_e        state, state_nxt;
  logic [NUM_ACKS-1:0] mask;
  logic [HW-1:0]       hold_cnt;
  logic                raising, falling;
  logic                accept, phase_wait, expired, fire;

  // Disabled channels read as "high" for the rise check and "low" for the fall check.
  assign raising = &(flush_ack | ~mask);
  assign falling = |(flush_ack & mask);
  assign accept  = start_valid && start_ready;

  always_comb begin
    state_nxt  = state;
    phase_wait = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = RAISE;
      RAISE: begin
        phase_wait = ~raising;
        if (raising || expired) state_nxt = HOLD;
      end
      HOLD:  if (hold_cnt == '0) state_nxt = FALL;
      FALL: begin
        phase_wait = falling;
        if (!falling || expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fire = phase_wait && expired;

  // Any state change restarts the wait count, so each phase starts from zero.
  hsv_core_flush_timeout #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timeout (
    .clk_core(clk_core),
    .rst_core(rst_core),
    .clr     (state_nxt != state),
    .en      (phase_wait),
    .expired (expired)
  );

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state        <= IDLE;
      mask         <= '0;
      hold_cnt     <= '0;
      flush_target <= '0;
      flush_done   <= 1'b0;
      timeout_o    <= 1'b0;
      stuck_o      <= '0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == FALL) && (state_nxt == IDLE);
      if (accept) begin
        flush_target <= start_target;
        mask         <= ack_enable;
      end
      if ((state == RAISE) && (state_nxt == HOLD)) begin
        hold_cnt <= HOLD_LOAD;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      if (fire) begin
        timeout_o <= 1'b1;
        stuck_o   <= (state == RAISE) ? (mask & ~flush_ack) : (mask & flush_ack);
      end else if (clear_err) begin
        timeout_o <= 1'b0;
        stuck_o   <= '0;
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign flush_busy  = (state != IDLE);
  assign flush_req   = (state == RAISE) || (state == HOLD);

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Bench for hsv_core_flush_ctrl: directed vector table, corner sequences and
// randomized transactions against a timing model derived from the ack schedule.
module tb_hsv_core_flush_ctrl;

  localparam int N  = 9;
  localparam int TW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, sv, clr;
  logic [TW-1:0] tgt;
  logic [N-1:0]  en, ack;

  logic          a_ready, a_req, a_busy, a_done, a_to;
  logic [TW-1:0] a_target;
  logic [N-1:0]  a_stuck;
  logic          b_ready, b_req, b_busy, b_done, b_to;
  logic [TW-1:0] b_target;
  logic [N-1:0]  b_stuck;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hsv_core_flush_ctrl #(.NUM_ACKS(N), .TARGET_W(TW), .HOLD_CYCLES(1), .TIMEOUT(TO)) dut_a (
    .clk_core(clk), .rst_core(rst), .start_valid(sv), .start_ready(a_ready),
    .start_target(tgt), .ack_enable(en), .flush_ack(ack), .flush_req(a_req),
    .flush_target(a_target), .flush_busy(a_busy), .flush_done(a_done),
    .timeout_o(a_to), .stuck_o(a_stuck), .clear_err(clr));

  hsv_core_flush_ctrl #(.NUM_ACKS(N), .TARGET_W(TW), .HOLD_CYCLES(3), .TIMEOUT(TO)) dut_b (
    .clk_core(clk), .rst_core(rst), .start_valid(sv), .start_ready(b_ready),
    .start_target(tgt), .ack_enable(en), .flush_ack(ack), .flush_req(b_req),
    .flush_target(b_target), .flush_busy(b_busy), .flush_done(b_done),
    .timeout_o(b_to), .stuck_o(b_stuck), .clear_err(clr));

  typedef struct {
    logic          sv;
    logic [TW-1:0] tgt;
    logic [N-1:0]  en;
    logic [N-1:0]  ack;
    logic          req, ready, busy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sv = 1'b0; clr = 1'b0; tgt = '0; en = '0; ack = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic addv(input logic s, input logic [TW-1:0] t, input logic [N-1:0] e,
                      input logic [N-1:0] a, input logic rq, input logic rd,
                      input logic bs, input logic dn);
    vec_t v;
    v.sv = s; v.tgt = t; v.en = e; v.ack = a;
    v.req = rq; v.ready = rd; v.busy = bs; v.done = dn;
    tbl.push_back(v);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".a_req"},    a_req,    0);
    chk({nm, ".a_busy"},   a_busy,   0);
    chk({nm, ".a_done"},   a_done,   0);
    chk({nm, ".a_ready"},  a_ready,  1);
    chk({nm, ".a_to"},     a_to,     0);
    chk({nm, ".a_stuck"},  a_stuck,  0);
    chk({nm, ".a_target"}, a_target, 0);
    chk({nm, ".b_req"},    b_req,    0);
    chk({nm, ".b_busy"},   b_busy,   0);
    chk({nm, ".b_done"},   b_done,   0);
    chk({nm, ".b_target"}, b_target, 0);
  endtask

  initial begin
    int rise[N];
    int fall[N];
    logic [N-1:0]  mask, a, rstuck, fstuck, exp_stuck;
    logic [TW-1:0] t_save;
    logic          exp_to, rto, fto, clr_now;
    int            rex, fex, hi, lasthi, donec, ndone;

    rst = 1'b0;
    do_reset();
    chk_reset_outputs("reset");

    // Directed table: all-enabled sequence, then masked sequence with ack 5 stuck high.
    addv(1, 32'h8000_0040, 9'h1FF, 9'h000, 0, 1, 0, 0);
    addv(0, 32'h0,         9'h000, 9'h000, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h000, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h1FF, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h1FF, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h1FF, 0, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h000, 0, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h000, 0, 1, 0, 1);
    addv(0, 32'h0,         9'h000, 9'h000, 0, 1, 0, 0);
    addv(1, 32'h0000_2222, 9'h003, 9'h020, 0, 1, 0, 0);
    addv(0, 32'h0,         9'h000, 9'h020, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h020, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h023, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h023, 1, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h023, 0, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h020, 0, 0, 1, 0);
    addv(0, 32'h0,         9'h000, 9'h020, 0, 1, 0, 1);
    addv(0, 32'h0,         9'h000, 9'h020, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      sv = tbl[i].sv; tgt = tbl[i].tgt; en = tbl[i].en; ack = tbl[i].ack;
      chk($sformatf("tbl%0d.req", i),   a_req,   tbl[i].req);
      chk($sformatf("tbl%0d.ready", i), a_ready, tbl[i].ready);
      chk($sformatf("tbl%0d.busy", i),  a_busy,  tbl[i].busy);
      chk($sformatf("tbl%0d.done", i),  a_done,  tbl[i].done);
      if (i == 7)  chk("tbl.target_a", a_target, 32'h8000_0040);
      if (i == 16) chk("tbl.target_b", a_target, 32'h0000_2222);
      tick();
    end
    chk("mask.timeout", a_to, 0);
    idle_inputs();
    tick();

    // Timeout: channel 3 never rises.
    sv = 1'b1; tgt = 32'h1234; en = 9'h1FF; ack = '0;
    tick();
    sv = 1'b0; ack = 9'h1F7;
    repeat (15) tick();
    chk("to.before", a_to, 0);
    chk("to.req_raise", a_req, 1);
    tick();
    chk("to.flag", a_to, 1);
    chk("to.stuck", a_stuck, 9'h008);
    chk("to.req_hold", a_req, 1);
    ack = '0;
    tick();
    chk("to.req_fall", a_req, 0);
    chk("to.busy_fall", a_busy, 1);
    tick();
    chk("to.done", a_done, 1);
    chk("to.sticky", a_to, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.flag", a_to, 0);
    chk("clr.stuck", a_stuck, 0);

    // Back-to-back: start_valid held through the done cycle.
    sv = 1'b1; tgt = 32'h200; en = '0; ack = '0;
    tick();
    tgt = 32'h100;
    chk("b2b.target1", a_target, 32'h200);
    chk("b2b.req1", a_req, 1);
    tick();
    tick();
    chk("b2b.ready_fall", a_ready, 0);
    tick();
    chk("b2b.done1", a_done, 1);
    chk("b2b.ready_done", a_ready, 1);
    tick();
    sv = 1'b0;
    chk("b2b.req2", a_req, 1);
    chk("b2b.target2", a_target, 32'h100);
    chk("b2b.done_gone", a_done, 0);
    tick();
    tick();
    tick();
    chk("b2b.done2", a_done, 1);
    idle_inputs();

    // Zero mask with HOLD_CYCLES=3 on the second instance.
    do_reset();
    hi = 0; lasthi = -1; donec = -1; ndone = 0;
    for (int j = 0; j < 10; j++) begin
      sv = (j == 0);
      tgt = 32'h55;
      if (b_req) begin hi++; lasthi = j; end
      if (b_done) begin donec = j; ndone++; end
      tick();
    end
    chk("hold3.req_cycles", hi, 4);
    chk("hold3.req_last", lasthi, 4);
    chk("hold3.done_at", donec, lasthi + 2);
    chk("hold3.done_count", ndone, 1);
    idle_inputs();

    // Reset while both instances sit in HOLD.
    do_reset();
    sv = 1'b1; tgt = 32'hABCD;
    tick();
    sv = 1'b0;
    tick();
    chk("rsthold.a_req", a_req, 1);
    chk("rsthold.b_req", b_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("rsthold");
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      if (a_done || b_done || a_busy || b_busy) ndone++;
      tick();
    end
    chk("rsthold.no_done", ndone, 0);

    // Randomized transactions on the HOLD_CYCLES=1 instance.
    do_reset();
    exp_to = 1'b0; exp_stuck = '0;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom);
      if ($urandom_range(0, 5) == 0) mask = '0;
      t_save = $urandom;
      for (int i = 0; i < N; i++) begin
        rise[i] = $urandom_range(0, 7);
        fall[i] = $urandom_range(0, 7);
        if ($urandom_range(0, 11) == 0) rise[i] = 40;
        if ($urandom_range(0, 11) == 0) fall[i] = 40;
      end
      rex = 0; fex = 0; rstuck = '0; fstuck = '0;
      for (int i = 0; i < N; i++) begin
        if (mask[i] && rise[i] > rex) rex = rise[i];
        if (mask[i] && fall[i] > fex) fex = fall[i];
        if (mask[i] && rise[i] > TO - 1) rstuck[i] = 1'b1;
        if (mask[i] && fall[i] > TO - 1) fstuck[i] = 1'b1;
      end
      rto = (rex > TO - 1);
      fto = (fex > TO - 1);
      if (rto) rex = TO - 1;
      if (fto) fex = TO - 1;
      clr_now = ($urandom_range(0, 3) == 0);

      sv = 1'b1; tgt = t_save; en = mask; ack = N'($urandom); clr = clr_now;
      chk($sformatf("rnd%0d.ready_idle", t), a_ready, 1);
      chk($sformatf("rnd%0d.busy_idle", t), a_busy, 0);
      if (clr_now) begin exp_to = 1'b0; exp_stuck = '0; end
      tick();
      clr = 1'b0;
      for (int k = 0; k <= rex; k++) begin
        for (int i = 0; i < N; i++) a[i] = mask[i] ? (k >= rise[i]) : 1'($urandom);
        ack = a; sv = 1'($urandom); tgt = $urandom; en = N'($urandom);
        chk($sformatf("rnd%0d.raise%0d.req", t, k), a_req, 1);
        chk($sformatf("rnd%0d.raise%0d.ready", t, k), a_ready, 0);
        tick();
      end
      ack = N'($urandom);
      chk($sformatf("rnd%0d.hold.req", t), a_req, 1);
      chk($sformatf("rnd%0d.hold.busy", t), a_busy, 1);
      tick();
      for (int k = 0; k <= fex; k++) begin
        for (int i = 0; i < N; i++) a[i] = mask[i] ? (k < fall[i]) : 1'($urandom);
        ack = a; sv = 1'($urandom); tgt = $urandom; en = N'($urandom);
        chk($sformatf("rnd%0d.fall%0d.req", t, k), a_req, 0);
        chk($sformatf("rnd%0d.fall%0d.busy", t, k), a_busy, 1);
        tick();
      end
      if (rto) begin exp_to = 1'b1; exp_stuck = rstuck; end
      if (fto) begin exp_to = 1'b1; exp_stuck = fstuck; end
      sv = 1'b0; ack = N'($urandom);
      chk($sformatf("rnd%0d.done", t), a_done, 1);
      chk($sformatf("rnd%0d.ready_done", t), a_ready, 1);
      chk($sformatf("rnd%0d.target", t), a_target, t_save);
      chk($sformatf("rnd%0d.timeout", t), a_to, exp_to);
      chk($sformatf("rnd%0d.stuck", t), a_stuck, exp_stuck);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
